his_rmw_scheduler: RTL and testbench

Shares one histogram SRAM between `NREQ` pixel front-ends, each posting TDC bin hits that must become read-modify-write increments. Round-robin arbitration issues at most one increment per cycle into a 2-stage RMW pipeline with read-after-write forwarding. A clear sequencer zeroes the whole memory between acquisitions. Sits between the per-pixel TDC/bin logic and the dual-port histogram RAM (port A write, port B read).

---
 rtl/his_rmw_scheduler.sv | 121 ++++++++++++
 tb/tb_his_rmw_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/his_rmw_scheduler.sv
// Round-robin histogram increment scheduler: 2-stage read-modify-write pipeline with forwarding and a full-memory clear.
// Define HIS_SAT_EN for saturating counts; without it counts wrap modulo 2**CNT_W.
module his_rmw_scheduler #(
    parameter int NREQ  = 4,
    parameter int PIX_W = 2,
    parameter int NB    = 10,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*NB-1:0]    req_bin,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  ram_ren,
    output logic [PIX_W+NB-1:0]   ram_raddr,
    input  logic [CNT_W-1:0]      ram_rdata,
    output logic                  ram_wen,
    output logic [PIX_W+NB-1:0]   ram_waddr,
    output logic [CNT_W-1:0]      ram_wdata
);
    localparam int AW = PIX_W + NB;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;
    state_t state, stateNext;

    logic [2**PIX_W-1:0] validPad;
    logic [PIX_W-1:0]    lastGrant, grantIdx, cand;
    logic                grantAny, canGrant;
    logic                vld_p1, fwd_p1, doneQ;
    logic [AW-1:0]       addr_p1, clrCnt;
    logic [CNT_W-1:0]    fwdData_p1, oldCnt;

    function automatic logic [CNT_W-1:0] incCount(input logic [CNT_W-1:0] old);
`ifdef HIS_SAT_EN
        return (&old) ? old : old + 1'b1;
`else
        return old + 1'b1;
`endif
    endfunction

    assign validPad = (2**PIX_W)'(req_valid);
    assign canGrant = (state == RUN) && !clr_start;

    // Search starts just after the previous winner and wraps at NREQ-1.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PIX_W'((int'(lastGrant) + k) % NREQ);
            if (!grantAny && validPad[cand]) begin
                grantAny = 1'b1;
                grantIdx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            RUN:     if (clr_start) stateNext = vld_p1 ? DRAIN : CLEAR;
            DRAIN:   stateNext = CLEAR;
            CLEAR:   if (clrCnt == LAST_ADDR) stateNext = RUN;
            default: stateNext = RUN;
        endcase
    end

    // Stage 0 (read issue) and stage 1 (write back) outputs
    always_comb begin
        req_ready = '0;
        ram_ren   = 1'b0;
        ram_raddr = '0;
        if (canGrant && grantAny) begin
            req_ready = NREQ'(1) << grantIdx;
            ram_ren   = 1'b1;
            ram_raddr = {grantIdx, req_bin[int'(grantIdx)*NB +: NB]};
        end
        // The RAM returns the pre-write value on a same-cycle read/write collision.
        oldCnt    = fwd_p1 ? fwdData_p1 : ram_rdata;
        ram_wen   = vld_p1 || (state == CLEAR);
        ram_waddr = vld_p1 ? addr_p1 : ((state == CLEAR) ? clrCnt : '0);
        ram_wdata = vld_p1 ? incCount(oldCnt) : '0;
        clr_busy  = (state != RUN);
        clr_done  = doneQ;
    end

    // Stage 0 -> stage 1 boundary: control
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            lastGrant <= PIX_W'(NREQ - 1);
            vld_p1    <= 1'b0;
            fwd_p1    <= 1'b0;
            clrCnt    <= '0;
            doneQ     <= 1'b0;
        end else begin
            vld_p1 <= ram_ren;
            fwd_p1 <= ram_ren && vld_p1 && (ram_raddr == addr_p1);
            if (ram_ren) lastGrant <= grantIdx;
            clrCnt <= (state == CLEAR) ? clrCnt + 1'b1 : '0;
            doneQ  <= (state == CLEAR) && (clrCnt == LAST_ADDR);
        end
    end

    // Stage 0 -> stage 1 boundary: data
    always_ff @(posedge clk) begin
        addr_p1    <= ram_raddr;
        fwdData_p1 <= ram_wdata;
    end
endmodule

// File: tb/tb_his_rmw_scheduler.sv
// Randomized bench for his_rmw_scheduler: behavioural histogram model, RAM model and directed scenario checks.
module tb_his_rmw_scheduler;
    localparam int NREQ  = 4;
    localparam int PIX_W = 2;
    localparam int NB    = 10;
    localparam int CNT_W = 8;
    localparam int AW    = PIX_W + NB;
    localparam int DEPTH = 2**AW;
`ifdef HIS_SAT_EN
    localparam int SAT_EXP = 255;
`else
    localparam int SAT_EXP = 0;
`endif

    logic clk = 1'b0;
    logic res = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*NB-1:0] req_bin = '0;
    logic [NREQ-1:0]    req_ready;
    logic               clr_start = 1'b0;
    logic               clr_busy, clr_done, ram_ren, ram_wen;
    logic [AW-1:0]      ram_raddr, ram_waddr;
    logic [CNT_W-1:0]   ram_rdata, ram_wdata;

    always #5 clk = ~clk;

    his_rmw_scheduler #(.NREQ(NREQ), .PIX_W(PIX_W), .NB(NB), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .req_valid(req_valid), .req_bin(req_bin), .req_ready(req_ready),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
    );

    // Dual-port RAM: registered read returning pre-write contents, plus a bench-side preload port.
    logic [CNT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] rdQ;
    logic             pokeEn = 1'b0;
    logic [AW-1:0]    pokeAddr = '0;
    logic [CNT_W-1:0] pokeData = '0;
    always @(posedge clk) begin
        if (ram_ren) rdQ <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (pokeEn) mem[pokeAddr] <= pokeData;
    end
    assign ram_rdata = rdQ;

    int nVec = 0;
    int nErr = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        int n;
        n = int'(v) + 1;
        if (n == 2**CNT_W) n = SAT_EXP;
        return CNT_W'(n);
    endfunction

    // Behavioural model: histogram array, round-robin pointer, pending write and clear progress.
    logic [CNT_W-1:0] hist [DEPTH];
    int mLast, clrPos, cyc;
    bit busy, drainLeft, doneNext, pendV;
    logic [AW-1:0]    pendA;
    logic [CNT_W-1:0] pendD;
    int wlA[$], wlD[$], wlC[$];

    always @(negedge clk) begin : compare
        int gi, j;
        bit wasPend;
        logic [NREQ-1:0]  eReady;
        logic             eRen, eWen;
        logic [AW-1:0]    eRaddr, eWaddr;
        logic [CNT_W-1:0] eWdata;
        if (!res) begin
            mLast = NREQ - 1; busy = 0; drainLeft = 0; doneNext = 0; pendV = 0; clrPos = 0;
            for (int i = 0; i < DEPTH; i++) hist[i] = mem[i];
        end else begin
            cyc++;
            gi = -1;
            if (!busy && !clr_start) begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (mLast + k) % NREQ;
                    if (gi < 0 && req_valid[j[1:0]]) gi = j;
                end
            end
            eReady = '0; eRen = 0; eRaddr = '0;
            if (gi >= 0) begin
                eReady = NREQ'(1) << gi;
                eRen   = 1;
                eRaddr = {gi[1:0], req_bin[gi*NB +: NB]};
            end
            if (pendV) begin
                eWen = 1; eWaddr = pendA; eWdata = pendD;
            end else if (busy && !drainLeft) begin
                eWen = 1; eWaddr = AW'(clrPos); eWdata = '0;
            end else begin
                eWen = 0; eWaddr = '0; eWdata = '0;
            end
            chk("req_ready", 32'(req_ready), 32'(eReady));
            chk("ram_ren", 32'(ram_ren), 32'(eRen));
            if (eRen) chk("ram_raddr", 32'(ram_raddr), 32'(eRaddr));
            chk("ram_wen", 32'(ram_wen), 32'(eWen));
            if (eWen) begin
                chk("ram_waddr", 32'(ram_waddr), 32'(eWaddr));
                chk("ram_wdata", 32'(ram_wdata), 32'(eWdata));
            end
            chk("clr_busy", 32'(clr_busy), 32'(busy));
            chk("clr_done", 32'(clr_done), 32'(doneNext));
            if (ram_wen) begin
                wlA.push_back(int'(ram_waddr)); wlD.push_back(int'(ram_wdata)); wlC.push_back(cyc);
            end
            wasPend = pendV;
            if (pokeEn) hist[pokeAddr] = pokeData;
            if (gi >= 0) begin
                mLast = gi;
                hist[eRaddr] = bump(hist[eRaddr]);
                pendV = 1; pendA = eRaddr; pendD = hist[eRaddr];
            end else begin
                pendV = 0;
            end
            doneNext = 0;
            if (busy) begin
                if (drainLeft) begin
                    drainLeft = 0;
                end else begin
                    hist[clrPos] = '0;
                    if (clrPos == DEPTH - 1) begin
                        busy = 0; doneNext = 1; clrPos = 0;
                    end else begin
                        clrPos++;
                    end
                end
            end else if (clr_start) begin
                busy = 1; drainLeft = wasPend; clrPos = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setBin(input int i, input int b);
        req_bin[i*NB +: NB] = NB'(b);
    endtask

    task automatic clearMem();
        int n;
        bit seen;
        n = 0; seen = 0;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (clr_done) seen = 1;
        end
        chk("clear_done_seen", 32'(seen), 1);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, zeros, nz, cnt3, cnt7, idx;
        bit seen;
        logic [NREQ-1:0] acc;
        int td[$], tc[$];

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_ren", 32'(ram_ren), 0);
        chk("rst_raddr", 32'(ram_raddr), 0);
        chk("rst_wen", 32'(ram_wen), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
        chk("rst_wdata", 32'(ram_wdata), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_done", 32'(clr_done), 0);
        @(posedge clk); #1;
        res = 1'b1;
        clearMem();

        // Requester 2, bin 5, three back-to-back hits
        wlA.delete(); wlD.delete(); wlC.delete();
        req_valid = 4'b0100; setBin(2, 5);
        repeat (3) tick();
        req_valid = '0;
        repeat (3) tick();
        foreach (wlA[i]) if (wlA[i] == 'h805) begin td.push_back(wlD[i]); tc.push_back(wlC[i]); end
        chk("triple_count", 32'(td.size()), 3);
        if (td.size() == 3) begin
            chk("triple_d0", 32'(td[0]), 1);
            chk("triple_d1", 32'(td[1]), 2);
            chk("triple_d2", 32'(td[2]), 3);
            chk("triple_gap01", 32'(tc[1] - tc[0]), 1);
            chk("triple_gap12", 32'(tc[2] - tc[1]), 1);
        end

        // All requesters valid: rotation resumes after requester 2
        for (int i = 0; i < NREQ; i++) setBin(i, $urandom_range(0, 31));
        req_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_onehot", 32'($countones(req_ready)), 1);
            idx = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
            chk("rr_order", 32'(idx), 32'((3 + k) % 4));
            tick();
            if (idx >= 0) setBin(idx, $urandom_range(0, 31));
        end
        req_valid = '0;
        repeat (2) tick();

        // clr_start the cycle after a hit is accepted: write, one DRAIN cycle, full clear
        req_valid = 4'b0010; setBin(1, 'h2A);
        @(negedge clk);
        chk("cah_accept", 32'(req_ready), 2);
        tick();
        req_valid = '0; clr_start = 1'b1;
        @(negedge clk);
        chk("cah_hit_wen", 32'(ram_wen), 1);
        chk("cah_hit_waddr", 32'(ram_waddr), 'h42A);
        chk("cah_hit_wdata", 32'(ram_wdata), 1);
        tick();
        clr_start = 1'b0;
        n = 0; zeros = 0; seen = 0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("cah_drain_wen", 32'(ram_wen), 0);
                chk("cah_drain_busy", 32'(clr_busy), 1);
            end
            if (clr_done) seen = 1;
            else if (ram_wen) zeros++;
        end
        chk("cah_done_latency", 32'(n), 4098);
        chk("cah_zero_writes", 32'(zeros), 4096);
        @(negedge clk);
        chk("cah_done_single", 32'(clr_done), 0);
        chk("cah_busy_low", 32'(clr_busy), 0);
        nz = 0;
        for (int a = 0; a < DEPTH; a++) if (mem[a] !== '0) nz++;
        chk("cah_all_zero", 32'(nz), 0);
        tick();

        // Count boundary: requester 1, bin 0x3FF preloaded to 255
        pokeEn = 1'b1; pokeAddr = 12'h7FF; pokeData = 8'hFF;
        tick();
        pokeEn = 1'b0; req_valid = 4'b0010; setBin(1, 'h3FF);
        @(negedge clk);
        chk("sat_accept", 32'(req_ready), 2);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("sat_wen", 32'(ram_wen), 1);
        chk("sat_waddr", 32'(ram_waddr), 'h7FF);
        chk("sat_wdata", 32'(ram_wdata), SAT_EXP);
        tick();

        // Random traffic with collisions, withdrawals and occasional clears
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            clr_start = ($urandom_range(0, 799) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || (req_valid[i] && $urandom_range(0, 15) == 0)) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    setBin(i, $urandom_range(0, 3));
                end
            end
        end
        req_valid = '0; clr_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clr_busy && n < 6000);
        chk("rand_idle", 32'(clr_busy), 0);
        tick();

        // Reset pulsed while clearing address 100
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0; seen = 0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (ram_wen && clr_busy && ram_waddr == 12'd100) seen = 1;
        end
        chk("rst_reach_100", 32'(seen), 1);
        #1 res = 1'b0;
        #1;
        chk("rstc_busy", 32'(clr_busy), 0);
        chk("rstc_done", 32'(clr_done), 0);
        chk("rstc_wen", 32'(ram_wen), 0);
        chk("rstc_waddr", 32'(ram_waddr), 0);
        chk("rstc_wdata", 32'(ram_wdata), 0);
        chk("rstc_ren", 32'(ram_ren), 0);
        tick();
        chk("rstc_busy_edge", 32'(clr_busy), 0);
        chk("rstc_wen_edge", 32'(ram_wen), 0);
        @(posedge clk); #1;
        res = 1'b1;

        // Requester 0 first after reset; requester 3 withdraws before acceptance
        wlA.delete(); wlD.delete(); wlC.delete();
        req_valid = 4'b1001; setBin(0, 7); setBin(3, 9);
        @(negedge clk);
        chk("wd_first_grant", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        repeat (4) tick();
        cnt3 = 0; cnt7 = 0;
        foreach (wlA[i]) begin
            if ((wlA[i] >> NB) == 3) cnt3++;
            if (wlA[i] == 7) cnt7++;
        end
        chk("wd_no_req3_write", 32'(cnt3), 0);
        chk("wd_req0_write", 32'(cnt7), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
